// File: rtl/data_cache_assoc.sv
// 2-way set-associative write-back/write-allocate data cache, one word per line.
// Misses are serviced over a req/ready backing-memory port; hits complete in one cycle.
module data_cache_assoc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int OFFSET_BITS = 3,
  parameter int NUM_SETS    = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [ADDR_WIDTH-1:0]  cpu_address,
  input  logic [DATA_WIDTH-1:0]  cpu_write_data,
  output logic [DATA_WIDTH-1:0]  cpu_read_data,
  output logic                   cpu_ready,
  output logic                   busy,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ready,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);
  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

  typedef struct packed {
    logic                  isWrite;
    logic                  way;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [DATA_WIDTH-1:0] data;
  } missReq_t;

  state_t   state, stateNext;
  missReq_t miss;

  logic [TAG_BITS-1:0]      tagArr  [2][NUM_SETS];
  logic [DATA_WIDTH-1:0]    dataArr [2][NUM_SETS];
  logic [1:0][NUM_SETS-1:0] validArr, dirtyArr;
  logic [NUM_SETS-1:0]      lru;

  logic                  reqValid, hit, hitWay, vicWay, vicDirty;
  logic [1:0]            wayHit;
  logic [INDEX_BITS-1:0] reqIndex;
  logic [TAG_BITS-1:0]   reqTag;
  logic [DATA_WIDTH-1:0] hitData;
  logic                  unusedOffset;

  logic                  arrWe, arrWay;
  logic [INDEX_BITS-1:0] arrIdx;
  logic [TAG_BITS-1:0]   arrTag;
  logic [DATA_WIDTH-1:0] arrData;

  assign reqValid     = cpu_read | cpu_write;
  assign reqIndex     = cpu_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign reqTag       = cpu_address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
  assign unusedOffset = ^cpu_address[OFFSET_BITS-1:0];

  assign wayHit[0] = validArr[0][reqIndex] && (tagArr[0][reqIndex] == reqTag);
  assign wayHit[1] = validArr[1][reqIndex] && (tagArr[1][reqIndex] == reqTag);
  assign hit       = |wayHit;
  assign hitWay    = wayHit[1];
  assign hitData   = dataArr[hitWay][reqIndex];

  // Fill empty ways in order before evicting anything.
  assign vicWay   = !validArr[0][reqIndex] ? 1'b0 :
                    !validArr[1][reqIndex] ? 1'b1 : lru[reqIndex];
  assign vicDirty = validArr[vicWay][reqIndex] & dirtyArr[vicWay][reqIndex];

  assign busy = (state != IDLE);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:      if (reqValid && !hit)
                   stateNext = vicDirty ? WRITEBACK : (cpu_write ? RESPOND : FILL);
      WRITEBACK: if (mem_ready) stateNext = miss.isWrite ? RESPOND : FILL;
      FILL:      if (mem_ready) stateNext = RESPOND;
      RESPOND:   stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITEBACK) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {tagArr[miss.way][miss.index], miss.index, {OFFSET_BITS{1'b0}}};
      mem_wdata = dataArr[miss.way][miss.index];
    end else if (state == FILL) begin
      mem_req  = 1'b1;
      mem_addr = {miss.tag, miss.index, {OFFSET_BITS{1'b0}}};
    end
  end

  // Single write port into the tag/data arrays: write hits, fills, write-miss installs.
  always_comb begin
    arrWe   = 1'b0;
    arrWay  = miss.way;
    arrIdx  = miss.index;
    arrTag  = miss.tag;
    arrData = miss.data;
    case (state)
      IDLE: if (reqValid && hit && cpu_write) begin
        arrWe   = 1'b1;
        arrWay  = hitWay;
        arrIdx  = reqIndex;
        arrTag  = reqTag;
        arrData = cpu_write_data;
      end
      FILL: if (mem_ready) begin
        arrWe   = 1'b1;
        arrData = mem_rdata;
      end
      RESPOND: arrWe = miss.isWrite;
      default: ;
    endcase
    if (reset) arrWe = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (arrWe) begin
      tagArr[arrWay][arrIdx]  <= arrTag;
      dataArr[arrWay][arrIdx] <= arrData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      validArr      <= '0;
      dirtyArr      <= '0;
      lru           <= '0;
      miss          <= '0;
      cpu_ready     <= 1'b0;
      cpu_read_data <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state     <= stateNext;
      cpu_ready <= 1'b0;
      case (state)
        IDLE: if (reqValid) begin
          if (hit) begin
            cpu_ready      <= 1'b1;
            cpu_read_data  <= cpu_write ? cpu_write_data : hitData;
            lru[reqIndex]  <= ~hitWay;
            if (cpu_write) dirtyArr[hitWay][reqIndex] <= 1'b1;
            if (hit_count != {COUNT_WIDTH{1'b1}}) hit_count <= hit_count + 1'b1;
          end else begin
            miss <= '{isWrite: cpu_write, way: vicWay, index: reqIndex,
                      tag: reqTag, data: cpu_write_data};
            if (miss_count != {COUNT_WIDTH{1'b1}}) miss_count <= miss_count + 1'b1;
          end
        end
        WRITEBACK: if (mem_ready) dirtyArr[miss.way][miss.index] <= 1'b0;
        FILL: if (mem_ready) begin
          validArr[miss.way][miss.index] <= 1'b1;
          dirtyArr[miss.way][miss.index] <= 1'b0;
          miss.data                      <= mem_rdata;
        end
        RESPOND: begin
          validArr[miss.way][miss.index] <= 1'b1;
          if (miss.isWrite) dirtyArr[miss.way][miss.index] <= 1'b1;
          lru[miss.index] <= ~miss.way;
          cpu_ready       <= 1'b1;
          cpu_read_data   <= miss.data;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache_assoc.sv
// Bench for data_cache_assoc: directed vector table, reset abort, counter saturation,
// and random traffic checked against a flat-memory + per-set LRU reference.
module tb_data_cache_assoc;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_address = '0, cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic        cpu_ready, busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] hit_count, miss_count;

  logic [31:0] unusedRd2, unusedAddr2, unusedWdata2;
  logic        unusedRdy2, unusedBusy2, unusedReq2, unusedWe2;
  logic [1:0]  hc2, mc2;

  always #5 clock = ~clock;

  data_cache_assoc dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count));

  // Narrow-counter copy driven by the same stimulus.
  data_cache_assoc #(.COUNT_WIDTH(2)) dutSat (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(unusedRd2), .cpu_ready(unusedRdy2), .busy(unusedBusy2),
    .mem_req(unusedReq2), .mem_we(unusedWe2), .mem_addr(unusedAddr2), .mem_wdata(unusedWdata2),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hc2), .miss_count(mc2));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit [31:0] initVal(bit [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Backing memory
  typedef struct { bit we; bit [31:0] addr, data; } memOp_t;
  memOp_t    memLog[$];
  bit [31:0] backing [bit [31:0]];
  int        memLat = 2, waitCnt = 0, reqCycles = 0;
  bit        memHold = 0, randLat = 0;

  always @(posedge clock) if (mem_req) reqCycles++;

  always @(negedge clock) begin
    memOp_t op;
    if (mem_ready) mem_ready = 1'b0;
    else if (mem_req && !memHold) begin
      if (waitCnt >= memLat) begin
        waitCnt = 0;
        mem_ready = 1'b1;
        op.we = mem_we; op.addr = mem_addr; op.data = mem_wdata;
        memLog.push_back(op);
        if (mem_we) backing[mem_addr] = mem_wdata;
        else mem_rdata = backing.exists(mem_addr) ? backing[mem_addr] : initVal(mem_addr);
        if (randLat) memLat = $urandom_range(0, 3);
      end else waitCnt++;
    end else waitCnt = 0;
  end

  task automatic access(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d,
                        output bit [31:0] rdOut, output int lat, output bit ok);
    @(negedge clock);
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_write_data = d;
    @(posedge clock); #1;
    cpu_read = 0; cpu_write = 0;
    lat = 1;
    while (!cpu_ready && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    ok = cpu_ready;
    rdOut = cpu_read_data;
  endtask

  typedef struct {
    bit rd, wr; bit [31:0] addr, wdata, expData;
    int expLat, expMemN; bit m0We; bit [31:0] m0Addr, m0Data; int expHit, expMiss;
  } vec_t;
  vec_t vecs[10];

  // Reference model state for the random phase
  bit [31:0] golden [bit [31:0]];
  bit [31:0] mruL[16], oldL[16];
  int        setCnt[16];

  initial begin
    bit [31:0] rdata;
    int lat, n0, r0, readyPulses, mHits, mMisses;
    bit ok;

    //          rd wr addr      wdata         expData       lat memN we addr      data          hit miss
    vecs[0] = '{1, 0, 32'h500, 32'h0,        32'h11111111, 0,  1,   0, 32'h500, 32'h0,        0,  1};
    vecs[1] = '{1, 0, 32'h500, 32'h0,        32'h11111111, 1,  0,   0, 32'h0,   32'h0,        1,  1};
    vecs[2] = '{0, 1, 32'h580, 32'hCAFEF00D, 32'hCAFEF00D, 2,  0,   0, 32'h0,   32'h0,        1,  2};
    vecs[3] = '{1, 0, 32'h580, 32'h0,        32'hCAFEF00D, 1,  0,   0, 32'h0,   32'h0,        2,  2};
    vecs[4] = '{1, 0, 32'h600, 32'h0,        32'hDEAD0600, 0,  1,   0, 32'h600, 32'h0,        2,  3};
    vecs[5] = '{1, 0, 32'h700, 32'h0,        32'hDEAD0700, 0,  2,   1, 32'h580, 32'hCAFEF00D, 2,  4};
    vecs[6] = '{1, 1, 32'h500, 32'h5,        32'h5,        2,  0,   0, 32'h0,   32'h0,        2,  5};
    vecs[7] = '{1, 0, 32'h504, 32'h0,        32'h5,        1,  0,   0, 32'h0,   32'h0,        3,  5};
    vecs[8] = '{1, 0, 32'h580, 32'h0,        32'hCAFEF00D, 0,  1,   0, 32'h580, 32'h0,        3,  6};
    vecs[9] = '{0, 1, 32'h700, 32'h77,       32'h77,       0,  1,   1, 32'h500, 32'h5,        3,  7};
    backing[32'h500] = 32'h11111111;

    // Reset state
    repeat (2) begin
      @(posedge clock); #1;
      chk("rst ready", cpu_ready, 0);
      chk("rst busy", busy, 0);
      chk("rst mem_req", mem_req, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst hits", hit_count, 0);
      chk("rst misses", miss_count, 0);
    end
    @(negedge clock); reset = 0;

    foreach (vecs[i]) begin
      n0 = memLog.size();
      r0 = reqCycles;
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, lat, ok);
      chk($sformatf("v%0d ready", i), ok, 1);
      chk($sformatf("v%0d data", i), rdata, vecs[i].expData);
      if (vecs[i].expLat != 0) chk($sformatf("v%0d latency", i), lat, vecs[i].expLat);
      chk($sformatf("v%0d memops", i), memLog.size() - n0, vecs[i].expMemN);
      if (vecs[i].expMemN == 0) chk($sformatf("v%0d reqcycles", i), reqCycles - r0, 0);
      else begin
        chk($sformatf("v%0d mem0 we", i), memLog[n0].we, vecs[i].m0We);
        chk($sformatf("v%0d mem0 addr", i), memLog[n0].addr, vecs[i].m0Addr);
        if (vecs[i].m0We) chk($sformatf("v%0d mem0 wdata", i), memLog[n0].data, vecs[i].m0Data);
      end
      chk($sformatf("v%0d hits", i), hit_count, vecs[i].expHit);
      chk($sformatf("v%0d misses", i), miss_count, vecs[i].expMiss);
    end

    // Reset while a fill is outstanding
    memHold = 1;
    @(negedge clock); cpu_read = 1; cpu_address = 32'h900;
    @(posedge clock); #1; cpu_read = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("hold mem_req", mem_req, 1);
    chk("hold mem_we", mem_we, 0);
    chk("hold mem_addr", mem_addr, 32'h900);
    chk("hold busy", busy, 1);
    @(negedge clock); reset = 1;
    @(posedge clock); #1;
    chk("abort mem_req", mem_req, 0);
    chk("abort busy", busy, 0);
    chk("abort ready", cpu_ready, 0);
    chk("abort hits", hit_count, 0);
    chk("abort misses", miss_count, 0);
    @(negedge clock); reset = 0; memHold = 0;
    readyPulses = 0;
    repeat (3) begin @(posedge clock); #1; if (cpu_ready) readyPulses++; end
    chk("abort no pulse", readyPulses, 0);
    access(1, 0, 32'h900, 0, rdata, lat, ok);
    chk("post-abort ready", ok, 1);
    chk("post-abort miss", lat > 1, 1);
    chk("post-abort data", rdata, 32'hDEAD0900);
    chk("post-abort misses", miss_count, 1);

    // Saturation of the 2-bit counters
    repeat (5) begin
      access(1, 0, 32'h900, 0, rdata, lat, ok);
      chk("sat hit latency", lat, 1);
    end
    chk("sat hits wide", hit_count, 5);
    chk("sat hits narrow", hc2, 3);
    chk("sat misses narrow", mc2, 1);

    // Random traffic vs reference
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    golden = backing;
    for (int s = 0; s < 16; s++) setCnt[s] = 0;
    mHits = 0; mMisses = 0;
    randLat = 1;
    for (int k = 0; k < 300; k++) begin
      bit [31:0] a, blk, d, expD;
      bit rd, wr, isHit;
      int s;
      a   = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
      d   = $urandom;
      wr  = $urandom_range(0, 1);
      rd  = !wr || ($urandom_range(0, 7) == 0);
      blk = a & ~32'h7;
      s   = (a >> 3) & 15;
      isHit = (setCnt[s] >= 1 && mruL[s] == blk) || (setCnt[s] == 2 && oldL[s] == blk);
      if (isHit) begin
        if (mruL[s] != blk) begin oldL[s] = mruL[s]; mruL[s] = blk; end
        mHits++;
      end else begin
        if (setCnt[s] == 0) setCnt[s] = 1;
        else begin oldL[s] = mruL[s]; setCnt[s] = 2; end
        mruL[s] = blk;
        mMisses++;
      end
      if (wr) begin golden[blk] = d; expD = d; end
      else expD = golden.exists(blk) ? golden[blk] : initVal(blk);
      access(rd, wr, a, d, rdata, lat, ok);
      chk($sformatf("r%0d ready", k), ok, 1);
      chk($sformatf("r%0d data a=%0h", k, a), rdata, expD);
      chk($sformatf("r%0d hit a=%0h", k, a), lat == 1, isHit);
    end
    chk("rand hits", hit_count, mHits);
    chk("rand misses", miss_count, mMisses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
